shifter_secuencial: RTL and testbench

SHIFTER_SECUENCIAL -- requirements
Module: shifter_secuencial

---
 rtl/shifter_secuencial.sv | 102 ++++++++++
 tb/tb_shifter_secuencial.sv | 222 ++++++++++++++++++++++
 2 files changed

// File: rtl/shifter_secuencial.sv
// Sequential barrel-free shifter: one bit position per clock, result published on DONE.
// Shift count saturates at N; right shifts optionally replicate the MSB.
module shifter_secuencial #(
  parameter  int N  = 8,
  localparam int AW = $clog2(N) + 1
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          start,
  input  logic [N-1:0]  Ain,
  input  logic [AW-1:0] amt,
  input  logic          dir,
  input  logic          sel,
  output logic [N-1:0]  Aout,
  output logic          busy,
  output logic          done
);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    SHIFT = 2'd1,
    DONE  = 2'd2
  } state_t;

  state_t        state_q, state_d;
  logic [N-1:0]  work_q, work_d;
  logic [N-1:0]  aout_q, aout_d;
  logic [AW-1:0] cnt_q, cnt_d;
  logic          dir_q, dir_d;
  logic          sel_q, sel_d;
  logic [AW-1:0] amt_clamped;

  assign amt_clamped = (amt > AW'(N)) ? AW'(N) : amt;

  always_comb begin
    state_d = state_q;
    work_d  = work_q;
    aout_d  = aout_q;
    cnt_d   = cnt_q;
    dir_d   = dir_q;
    sel_d   = sel_q;
    case (state_q)
      IDLE: begin
        if (start) begin
          work_d  = Ain;
          dir_d   = dir;
          sel_d   = sel;
          cnt_d   = amt_clamped;
          state_d = (amt_clamped != '0) ? SHIFT : DONE;
        end
      end
      SHIFT: begin
        if (cnt_q == '0) begin
          state_d = DONE;
        end else begin
          if (dir_q) begin
            work_d = {work_q[N-2:0], 1'b0};
          end else begin
            work_d = {sel_q & work_q[N-1], work_q[N-1:1]};
          end
          cnt_d = cnt_q - AW'(1);
          if (cnt_d == '0) begin
            state_d = DONE;
          end
        end
      end
      DONE: begin
        state_d = IDLE;
      end
      default: begin
        state_d = IDLE;
      end
    endcase
    // Publish on entry to DONE so Aout is already valid while done is high.
    if (state_d == DONE) begin
      aout_d = work_d;
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q <= IDLE;
      work_q  <= '0;
      aout_q  <= '0;
      cnt_q   <= '0;
      dir_q   <= 1'b0;
      sel_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      work_q  <= work_d;
      aout_q  <= aout_d;
      cnt_q   <= cnt_d;
      dir_q   <= dir_d;
      sel_q   <= sel_d;
    end
  end

  assign Aout = aout_q;
  assign busy = (state_q != IDLE);
  assign done = (state_q == DONE);

endmodule

// File: tb/tb_shifter_secuencial.sv
// Scoreboard bench for shifter_secuencial (N=8): expectations pushed at start, popped at done.
module tb_shifter_secuencial;
  localparam int N  = 8;
  localparam int AW = 4;

  logic          clk = 1'b0;
  logic          rst_n, start, dir, sel;
  logic [N-1:0]  Ain, Aout;
  logic [AW-1:0] amt;
  logic          busy, done;

  typedef struct {
    logic [7:0] aout;
    int         lat;
  } exp_t;

  exp_t       sb[$];
  int         n_cmp = 0;
  int         n_err = 0;
  logic [7:0] last_aout;

  shifter_secuencial #(.N(N)) dut (
    .clk(clk), .rst_n(rst_n), .start(start), .Ain(Ain), .amt(amt),
    .dir(dir), .sel(sel), .Aout(Aout), .busy(busy), .done(done)
  );

  always #5 clk = ~clk;

  // Reference result computed with native shift operators.
  function automatic logic [7:0] model(input logic [7:0] a, input logic [AW-1:0] s,
                                       input logic d, input logic sl);
    int         c;
    logic [7:0] r;
    c = (int'(s) > N) ? N : int'(s);
    if (d) r = a << c;
    else if (sl) r = 8'($signed(a) >>> c);
    else r = a >> c;
    return r;
  endfunction

  function automatic int exp_lat(input logic [AW-1:0] s);
    return ((int'(s) > N) ? N : int'(s)) + 1;
  endfunction

  // Drives one start pulse, then scrambles the inputs to prove they were latched.
  task automatic drive_start(input logic [7:0] a, input logic [AW-1:0] s,
                             input logic d, input logic sl);
    exp_t e;
    @(negedge clk);
    Ain = a; amt = s; dir = d; sel = sl; start = 1'b1;
    e.aout = model(a, s, d, sl);
    e.lat  = exp_lat(s);
    sb.push_back(e);
    @(posedge clk);
    #1;
    start = 1'b0; Ain = ~a; amt = ~s; dir = ~d; sel = ~sl;
  endtask

  // Observes cycles after the start edge; optionally pulses a stray start mid-operation.
  task automatic wait_done(input int inj_cycle, output bit seen, output int lat,
                           output int busy_cnt, output logic [7:0] aout_v,
                           output logic done_after, output logic busy_after,
                           output bit mid_ok);
    seen = 1'b0; lat = 0; busy_cnt = 0; aout_v = 'x;
    done_after = 1'bx; busy_after = 1'bx; mid_ok = 1'b1;
    for (int c = 1; c <= 40; c++) begin
      @(negedge clk);
      if (busy === 1'b1) busy_cnt++;
      if (done === 1'b1) begin
        seen = 1'b1; lat = c; aout_v = Aout;
        @(negedge clk);
        done_after = done; busy_after = busy;
        break;
      end
      if (Aout !== last_aout) mid_ok = 1'b0;
      if (c == inj_cycle) begin
        start = 1'b1; Ain = 8'h01; amt = 4'd1; dir = 1'b1; sel = 1'b0;
      end else if (c == inj_cycle + 1) begin
        start = 1'b0;
      end
    end
    start = 1'b0;
  endtask

  task automatic test_reset();
    rst_n = 1'b0; start = 1'b1; Ain = 8'hA5; amt = 4'd2; dir = 1'b1; sel = 1'b0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    n_cmp++;
    if (Aout !== 8'h00) begin n_err++; $display("[TB] FAIL reset_aout got=%h exp=00", Aout); end
    n_cmp++;
    if (busy !== 1'b0) begin n_err++; $display("[TB] FAIL reset_busy got=%b exp=0", busy); end
    n_cmp++;
    if (done !== 1'b0) begin n_err++; $display("[TB] FAIL reset_done got=%b exp=0", done); end
    start = 1'b0;
    rst_n = 1'b1;
    last_aout = 8'h00;
  endtask

  task automatic test_shift_table();
    logic [7:0]    t_a[7]  = '{8'h96, 8'h96, 8'h96, 8'h5A, 8'h81, 8'hC3, 8'h7F};
    logic [AW-1:0] t_s[7]  = '{4'd3, 4'd2, 4'd2, 4'd0, 4'd1, 4'd7, 4'd9};
    logic          t_d[7]  = '{1'b1, 1'b0, 1'b0, 1'b1, 1'b0, 1'b1, 1'b1};
    logic          t_sl[7] = '{1'b0, 1'b0, 1'b1, 1'b0, 1'b1, 1'b1, 1'b0};
    bit seen, mid_ok; int lat, bcnt; logic [7:0] av; logic da, ba; exp_t e;
    for (int i = 0; i < 13; i++) begin
      if (i < 7) drive_start(t_a[i], t_s[i], t_d[i], t_sl[i]);
      else drive_start(8'($urandom), 4'($urandom_range(0, 15)), 1'($urandom), 1'($urandom));
      wait_done(0, seen, lat, bcnt, av, da, ba, mid_ok);
      e = sb.pop_front();
      n_cmp++;
      if (!seen) begin
        n_err++; $display("[TB] FAIL op%0d_timeout got=no_done exp=done", i);
        continue;
      end
      if (av !== e.aout) begin n_err++; $display("[TB] FAIL op%0d_aout got=%h exp=%h", i, av, e.aout); end
      n_cmp++;
      if (lat != e.lat) begin n_err++; $display("[TB] FAIL op%0d_latency got=%0d exp=%0d", i, lat, e.lat); end
      n_cmp++;
      if (bcnt != e.lat) begin n_err++; $display("[TB] FAIL op%0d_busy_cycles got=%0d exp=%0d", i, bcnt, e.lat); end
      n_cmp++;
      if (da !== 1'b0 || ba !== 1'b0) begin
        n_err++; $display("[TB] FAIL op%0d_pulse got=done%b/busy%b exp=0/0", i, da, ba);
      end
      n_cmp++;
      if (!mid_ok) begin n_err++; $display("[TB] FAIL op%0d_aout_hold got=changed exp=%h", i, last_aout); end
      last_aout = e.aout;
    end
  endtask

  task automatic test_saturate_ignore();
    bit seen, mid_ok; int lat, bcnt; logic [7:0] av; logic da, ba; exp_t e;
    drive_start(8'h96, 4'd15, 1'b0, 1'b1);
    wait_done(3, seen, lat, bcnt, av, da, ba, mid_ok);
    e = sb.pop_front();
    n_cmp++;
    if (!seen || av !== 8'hFF) begin n_err++; $display("[TB] FAIL sat_aout got=%h exp=FF", av); end
    n_cmp++;
    if (lat != 9) begin n_err++; $display("[TB] FAIL sat_latency got=%0d exp=9", lat); end
    n_cmp++;
    if (da !== 1'b0 || ba !== 1'b0) begin n_err++; $display("[TB] FAIL sat_stray_start got=done%b/busy%b exp=0/0", da, ba); end
    n_cmp++;
    if (Aout !== 8'hFF) begin n_err++; $display("[TB] FAIL sat_hold got=%h exp=FF", Aout); end
    last_aout = e.aout;
  endtask

  task automatic test_back_to_back();
    bit seen, mid_ok; int lat, bcnt; logic [7:0] av; logic da, ba; exp_t e;
    @(negedge clk);
    Ain = 8'h3C; amt = 4'd0; dir = 1'b1; sel = 1'b0; start = 1'b1;
    e.aout = model(8'h3C, 4'd0, 1'b1, 1'b0); e.lat = exp_lat(4'd0);
    sb.push_back(e);
    @(negedge clk);
    e = sb.pop_front();
    n_cmp++;
    if (done !== 1'b1 || Aout !== e.aout) begin
      n_err++; $display("[TB] FAIL b2b_first got=done%b/%h exp=done1/%h", done, Aout, e.aout);
    end
    last_aout = e.aout;
    @(negedge clk);
    start = 1'b0;
    n_cmp++;
    if (busy !== 1'b0 || done !== 1'b0) begin
      n_err++; $display("[TB] FAIL b2b_done_start got=busy%b/done%b exp=0/0", busy, done);
    end
    drive_start(8'h0F, 4'd4, 1'b1, 1'b0);
    wait_done(0, seen, lat, bcnt, av, da, ba, mid_ok);
    e = sb.pop_front();
    n_cmp++;
    if (!seen || av !== e.aout || lat != e.lat) begin
      n_err++; $display("[TB] FAIL b2b_second got=%h/lat%0d exp=%h/lat%0d", av, lat, e.aout, e.lat);
    end
    last_aout = e.aout;
  endtask

  task automatic test_reset_abort();
    bit seen, mid_ok; int lat, bcnt; logic [7:0] av; logic da, ba; exp_t e;
    logic bad;
    bad = 1'b0;
    drive_start(8'hFF, 4'd8, 1'b1, 1'b0);
    for (int c = 1; c <= 3; c++) begin
      @(negedge clk);
      if (done !== 1'b0 || busy !== 1'b1 || Aout !== last_aout) bad = 1'b1;
    end
    n_cmp++;
    if (bad) begin n_err++; $display("[TB] FAIL abort_pre got=bad_state exp=busy/no_done/held"); end
    @(negedge clk);
    rst_n = 1'b0;
    @(negedge clk);
    n_cmp++;
    if (Aout !== 8'h00 || busy !== 1'b0 || done !== 1'b0) begin
      n_err++; $display("[TB] FAIL abort_reset got=%h/busy%b/done%b exp=00/0/0", Aout, busy, done);
    end
    sb.delete();
    last_aout = 8'h00;
    rst_n = 1'b1; Ain = 8'h01; amt = 4'd1; dir = 1'b1; sel = 1'b0; start = 1'b1;
    e.aout = model(8'h01, 4'd1, 1'b1, 1'b0); e.lat = exp_lat(4'd1);
    sb.push_back(e);
    @(posedge clk);
    #1;
    start = 1'b0;
    wait_done(0, seen, lat, bcnt, av, da, ba, mid_ok);
    e = sb.pop_front();
    n_cmp++;
    if (!seen || av !== 8'h02 || av !== e.aout) begin
      n_err++; $display("[TB] FAIL abort_restart got=%h exp=%h", av, e.aout);
    end
    n_cmp++;
    if (lat != 2) begin n_err++; $display("[TB] FAIL abort_restart_lat got=%0d exp=2", lat); end
  endtask

  initial begin
    test_reset();
    test_shift_table();
    test_saturate_ignore();
    test_back_to_back();
    test_reset_abort();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
